// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory store path.
// Provides the request size encodings, the store RMW state enum, and a helper
// that flags misaligned or illegal store requests.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } reqSize_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    FAULT = 3'd4
  } rmwState_e;

  // A request faults when its size is illegal or its byte offset is not a
  // multiple of its size. Byte stores can never be misaligned.
  function automatic logic isStoreFault(input reqSize_e size, input logic [1:0] lane);
    case (size)
      SZ_HALF:    return lane[0];
      SZ_WORD:    return lane != 2'b00;
      SZ_ILLEGAL: return 1'b1;
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Little-endian lane merge: drops a byte, halfword or word of new data into an
// existing 32-bit memory word.
// Ports:
//   oldWord - word currently held in memory
//   data    - store data; only the low 8/16 bits are used for byte/half
//   size    - store size encoding
//   lane    - byte offset within the word (addr[1:0])
//   merged  - resulting word to write back
module store_lane_merge
  import mips_mem_pkg::*;
(
  input  logic [31:0] oldWord,
  input  logic [31:0] data,
  input  reqSize_e    size,
  input  logic [1:0]  lane,
  output logic [31:0] merged
);

  always_comb begin
    merged = oldWord;
    case (size)
      SZ_BYTE: merged[{lane, 3'b000} +: 8]        = data[7:0];
      // Halfword lane is 0 or 2; lane[0] is already rejected as a fault.
      SZ_HALF: merged[{lane[1], 4'b0000} +: 16]   = data[15:0];
      SZ_WORD: merged                             = data;
      default: merged                             = oldWord;
    endcase
  end

endmodule

// File: rtl/store_rmw_unit.sv
// Store unit between the MEM-stage store request and word-organised data
// memory. Word stores write directly; byte/half stores read the word, merge
// the lane and write it back. All memory strobes are held until ack.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   i_req_valid/o_req_ready, i_req_size/addr/data - store request handshake
//   o_mem_addr/rd/wr/wdata, i_mem_rdata/ack       - ack-based memory port
//   o_done  - one-cycle pulse when the store has been committed
//   o_fault - one-cycle pulse for misaligned/illegal requests (no access)
//
// state | meaning
// IDLE  | ready for a request; captures it on valid
// READ  | rd strobe held for the old word until ack
// WRITE | wr strobe held with the merged/word data until ack
// DONE  | o_done pulse, not ready
// FAULT | o_fault pulse, not ready
module store_rmw_unit
  import mips_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [1:0]            i_req_size,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [31:0]           i_req_data,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_rd,
  output logic                  o_mem_wr,
  output logic [31:0]           o_mem_wdata,
  input  logic [31:0]           i_mem_rdata,
  input  logic                  i_mem_ack,
  output logic                  o_done,
  output logic                  o_fault
);

  rmwState_e   state;
  reqSize_e    capSize;
  logic [1:0]  capLane;
  logic [31:0] capData;
  logic [31:0] mergedWord;
  reqSize_e    reqSize;

  assign reqSize = reqSize_e'(i_req_size);

  store_lane_merge uMerge (
    .oldWord (i_mem_rdata),
    .data    (capData),
    .size    (capSize),
    .lane    (capLane),
    .merged  (mergedWord)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      o_req_ready <= 1'b1;
      o_mem_addr  <= '0;
      o_mem_rd    <= 1'b0;
      o_mem_wr    <= 1'b0;
      o_mem_wdata <= '0;
      o_done      <= 1'b0;
      o_fault     <= 1'b0;
      capSize     <= SZ_BYTE;
      capLane     <= 2'b00;
      capData     <= '0;
    end else begin
      o_done  <= 1'b0;
      o_fault <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            capSize     <= reqSize;
            capLane     <= i_req_addr[1:0];
            capData     <= i_req_data;
            o_req_ready <= 1'b0;
            if (isStoreFault(reqSize, i_req_addr[1:0])) begin
              state   <= FAULT;
              o_fault <= 1'b1;
            end else begin
              o_mem_addr <= {i_req_addr[ADDR_WIDTH-1:2], 2'b00};
              if (reqSize == SZ_WORD) begin
                state       <= WRITE;
                o_mem_wr    <= 1'b1;
                o_mem_wdata <= i_req_data;
              end else begin
                state    <= READ;
                o_mem_rd <= 1'b1;
              end
            end
          end
        end
        READ: begin
          if (i_mem_ack) begin
            state       <= WRITE;
            o_mem_rd    <= 1'b0;
            o_mem_wr    <= 1'b1;
            o_mem_wdata <= mergedWord;
          end
        end
        WRITE: begin
          if (i_mem_ack) begin
            state    <= DONE;
            o_mem_wr <= 1'b0;
            o_done   <= 1'b1;
          end
        end
        DONE, FAULT: begin
          state       <= IDLE;
          o_req_ready <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          o_req_ready <= 1'b1;
          o_mem_rd    <= 1'b0;
          o_mem_wr    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/store_rmw_unit.md
Name: store_rmw_unit

Overview:
- Store-side counterpart to the datapath's immediate/load widening: narrows a 32-bit register value to byte/halfword/word and writes it into word-organised data memory.
- Word stores write directly; sb/sh perform read-modify-write (read word, merge lane, write back) over an ack-based memory port.
- Sits between the MEM-stage store request and the data memory; the pipeline stalls on o_req_ready.

Parameters:
- ADDR_WIDTH, 32, byte address width; memory address is word-aligned, with the low 2 bits forced to 0.

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high reset
- i_req_valid  in  1  store request present
- o_req_ready  out  1  unit idle, request accepted this cycle if valid
- i_req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- i_req_addr  in  ADDR_WIDTH  byte address
- i_req_data  in  32  register value; only the low 8/16/32 bits are used
- o_mem_addr  out  ADDR_WIDTH  word address {addr[ADDR_WIDTH-1:2],2'b00}
- o_mem_rd  out  1  read strobe, held until ack
- o_mem_wr  out  1  write strobe, held until ack
- o_mem_wdata  out  32  merged word
- i_mem_rdata  in  32  read data, valid with ack during a read
- i_mem_ack  in  1  completes the current rd or wr
- o_done  out  1  one-cycle pulse: store committed
- o_fault  out  1  one-cycle pulse: misaligned or illegal size; no memory access

Behaviour:
- Reset values: all outputs 0 except o_req_ready=1; state IDLE; captured registers cleared.
- States:
  - IDLE: ready=1. On valid and ready, capture addr, size and data.
    - Fault condition: size=11, half with addr[0]=1, or word with addr[1:0]!=0. Go to FAULT.
    - Word store: go to WRITE.
    - Byte or half store: go to READ.
  - READ: o_mem_rd=1, o_mem_addr is the word address. On i_mem_ack, register merged = lane_merge(i_mem_rdata). Go to WRITE.
  - WRITE: o_mem_wr=1, o_mem_wdata=merged (word store: the captured data). On ack, go to DONE.
  - DONE: o_done=1 for one cycle, ready=0. Go to IDLE.
  - FAULT: o_fault=1 for one cycle, ready=0. Go to IDLE.
- Strobes are registered outputs of state and are never both high.
- Merge is little-endian; lane = addr[1:0].
  - Byte: replaces bits [8*lane+7 : 8*lane] with data[7:0].
  - Half: lane 0 replaces [15:0], lane 2 replaces [31:16], with data[15:0].
  - Upper bits of i_req_data are ignored; no sign handling.
- Latency with zero-wait memory (ack in the first strobe cycle), accept at cycle T:
  - Word: wr at T+1, o_done at T+2.
  - Byte/half: rd at T+1, wr at T+2, o_done at T+3.
  - Each wait cycle without ack adds one cycle.
- Boundary conditions:
  - Requests while busy: ignored (ready=0); the requester holds its request.
  - i_mem_ack outside READ/WRITE: ignored.
  - Reset in any state: IDLE next edge, strobes low, transaction dropped, no o_done.
  - Back-to-back: the next request is accepted in the IDLE cycle after DONE/FAULT.

Decomposition:
- Shared package (mips_mem_pkg):
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILLEGAL
  - state enum IDLE/READ/WRITE/DONE/FAULT
- Combinational sub-module: store_lane_merge (old word, data, size, lane -> merged word), reusable by the load path's lane select.

Test Plan:
- sw addr 0x1000 data 0xCAFEBABE, ack in first strobe cycle -> single wr 0xCAFEBABE to 0x1000, no rd, o_done at T+2.
- sb addr 0x1003 data 0x123456AB, memory holds 0x11223344 -> rd 0x1000, then wr 0xAB223344, o_done at T+3.
- sh addr 0x2002 data 0x1234CAFE, memory holds 0xDEADBEEF -> wr 0xCAFEBEEF to 0x2000.
- sh addr 0x1001, then sw addr 0x1006, then size=11 -> three o_fault pulses; o_mem_rd/o_mem_wr never asserted.
- sb with ack delayed 3 cycles on read and 2 on write -> strobes held stable, address and data stable, o_done at T+8; a second valid during busy is not accepted.
- Reset asserted during READ -> next cycle strobes 0, o_req_ready=1, no o_done; a following sw completes normally.
